// File: rtl/bd_sync_pkg.sv
// Shared definitions for the bundled-data receive bridge: FSM encodings,
// synchroniser depth floor and pointer sizing.
package bd_sync_pkg;

  localparam int unsigned SYNC_MIN = 2;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } bdState_e;

  // Index width for a power-of-two FIFO; never narrower than one bit.
  function automatic int unsigned ptrWidth(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/bd_sync_ff.sv
// N-stage flop chain bringing an asynchronous level into the clk domain.
module bd_sync_ff
  import bd_sync_pkg::*;
#(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  localparam int unsigned N = (STAGES < SYNC_MIN) ? SYNC_MIN : STAGES;

  logic [N-1:0] chain;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[N-2:0], d};
    end
  end

  assign q = chain[N-1];

endmodule

// File: rtl/bd_rx_sync_bridge.sv
// Receives 2-phase bundled-data words from an async pipeline, buffers them in a
// small FIFO and presents them as a valid/ready stream in the clk domain.
module bd_rx_sync_bridge
  import bd_sync_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inR,
  input  logic [DATA_W-1:0]        inData,
  output logic                     outA,
  output logic                     oValid,
  output logic [DATA_W-1:0]        oData,
  input  logic                     iReady,
  output logic [$clog2(DEPTH):0]   oCount,
  output logic                     oStall
);

  localparam int unsigned PTR_W  = ptrWidth(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned STAGES = (SYNC_STAGES < SYNC_MIN) ? SYNC_MIN : SYNC_STAGES;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic              reqS;
  logic              lastReq;
  logic              pendingC;
  logic              popC;
  logic              pushC;
  logic              fullC;
  logic              stallC;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  cntNext;
  logic [PTR_W-1:0]  wPtr;
  logic [PTR_W-1:0]  rPtr;
  logic [DATA_W-1:0] mem [DEPTH];
  bdState_e          state;
  bdState_e          stateNext;

  bd_sync_ff #(
    .STAGES (STAGES)
  ) u_reqSync (
    .clk (clk),
    .rst (rst),
    .d   (inR),
    .q   (reqS)
  );

  // A phase difference between the synchronised request and the last
  // acknowledged phase means one word is waiting on inData.
  assign pendingC = reqS ^ lastReq;
  assign popC     = oValid & iReady;
  assign fullC    = (count == FULL_CNT);
  assign pushC    = pendingC & (~fullC | popC);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (pendingC && !pushC) stateNext = HOLD;
      HOLD:    if (pushC)              stateNext = IDLE;
      default:                         stateNext = IDLE;
    endcase
  end

  always_comb begin
    stallC = 1'b0;
    if (state == HOLD) stallC = 1'b1;
  end

  assign oStall = stallC;

  // Capture side: data is sampled raw, it has been stable since before reqS moved.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wPtr    <= '0;
      lastReq <= 1'b0;
      outA    <= 1'b0;
    end else if (pushC) begin
      wPtr    <= wPtr + PTR_W'(1);
      lastReq <= reqS;
      outA    <= ~outA;
    end
  end

  always_ff @(posedge clk) begin
    if (pushC) mem[wPtr] <= inData;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rPtr <= '0;
    end else if (popC) begin
      rPtr <= rPtr + PTR_W'(1);
    end
  end

  always_comb begin
    cntNext = count;
    case ({pushC, popC})
      2'b10:   cntNext = count + CNT_W'(1);
      2'b01:   cntNext = count - CNT_W'(1);
      default: cntNext = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= '0;
      oValid <= 1'b0;
    end else begin
      count  <= cntNext;
      oValid <= (cntNext != '0);
    end
  end

  assign oCount = count;
  // Head word is forced to zero when empty so the output is clean during reset.
  assign oData  = oValid ? mem[rPtr] : '0;

endmodule

// File: tb/tb_bd_rx_sync_bridge.sv
// Directed bench for bd_rx_sync_bridge: reset, latency, back-pressure,
// full push/pop, streaming with wrap, and reset mid-transfer.
module tb_bd_rx_sync_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        inR;
  logic [31:0] inData;
  logic        outA;
  logic        oValid;
  logic [31:0] oData;
  logic        iReady;
  logic [2:0]  oCount;
  logic        oStall;

  int   nVec = 0;
  int   nErr = 0;
  logic expA = 1'b0;

  always #5 clk = ~clk;

  bd_rx_sync_bridge #(
    .DATA_W      (32),
    .DEPTH       (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .inR    (inR),
    .inData (inData),
    .outA   (outA),
    .oValid (oValid),
    .oData  (oData),
    .iReady (iReady),
    .oCount (oCount),
    .oStall (oStall)
  );

  task automatic toggleReq(input logic [31:0] d);
    inData = d;
    inR    = ~inR;
  endtask

  task automatic waitAck(input logic prevA, input int limit, output int edges);
    edges = 0;
    for (int e = 1; e <= limit; e++) begin
      @(negedge clk);
      if (outA !== prevA) begin
        edges = e;
        break;
      end
    end
    nVec++;
    if (edges == 0) begin
      nErr++;
      $display("FAIL ack_timeout: outA=%b still equal to %b after %0d edges", outA, prevA, limit);
    end
  endtask

  task automatic send(input logic [31:0] d, input int limit);
    logic prev;
    int   e;
    prev = outA;
    toggleReq(d);
    waitAck(prev, limit, e);
    expA = ~expA;
  endtask

  task automatic test_reset;
    rst    = 1'b0;
    inR    = 1'b0;
    inData = '0;
    iReady = 1'b0;
    repeat (3) @(negedge clk);
    nVec++;
    if ({outA, oValid, oCount, oStall, oData} !== 38'd0) begin
      nErr++;
      $display("FAIL reset_hold: got %b/%b/%0d/%b/%h, want all zero", outA, oValid, oCount, oStall, oData);
    end
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      nVec++;
      if ({outA, oValid, oCount, oStall} !== 6'd0) begin
        nErr++;
        $display("FAIL idle_quiet cyc%0d: got A=%b V=%b C=%0d S=%b, want zeros", i, outA, oValid, oCount, oStall);
      end
    end
    expA = 1'b0;
  endtask

  task automatic test_single;
    int e;
    iReady = 1'b1;
    toggleReq(32'hDEADBEEF);
    waitAck(1'b0, 8, e);
    expA = 1'b1;
    nVec++;
    if (e < 3 || e > 4) begin
      nErr++;
      $display("FAIL single_latency: got %0d edges, want 3..4", e);
    end
    nVec++;
    if (oValid !== 1'b1 || oData !== 32'hDEADBEEF) begin
      nErr++;
      $display("FAIL single_head: got V=%b D=%h, want V=1 D=deadbeef", oValid, oData);
    end
    @(negedge clk);
    nVec++;
    if (oValid !== 1'b0 || oCount !== 3'd0 || outA !== 1'b1) begin
      nErr++;
      $display("FAIL single_drain: got V=%b C=%0d A=%b, want V=0 C=0 A=1", oValid, oCount, outA);
    end
  endtask

  task automatic test_fill_stall;
    logic prev;
    iReady = 1'b0;
    for (int i = 1; i <= 4; i++) send(32'(i), 16);
    nVec++;
    if (oCount !== 3'd4 || outA !== expA || oData !== 32'd1) begin
      nErr++;
      $display("FAIL fill: got C=%0d A=%b D=%h, want C=4 A=%b D=1", oCount, outA, oData, expA);
    end
    prev = outA;
    toggleReq(32'd5);
    repeat (6) @(negedge clk);
    nVec++;
    if (oStall !== 1'b1 || outA !== prev || oCount !== 3'd4 || oData !== 32'd1) begin
      nErr++;
      $display("FAIL stall: got S=%b A=%b C=%0d D=%h, want S=1 A=%b C=4 D=1", oStall, outA, oCount, oData, prev);
    end
    iReady = 1'b1;
    @(negedge clk);
    expA = ~expA;
    nVec++;
    if (outA !== expA || oStall !== 1'b0 || oCount !== 3'd4 || oData !== 32'd2) begin
      nErr++;
      $display("FAIL stall_release: got A=%b S=%b C=%0d D=%h, want A=%b S=0 C=4 D=2", outA, oStall, oCount, oData, expA);
    end
    for (int k = 3; k <= 5; k++) begin
      @(negedge clk);
      nVec++;
      if (oData !== 32'(k) || oCount !== 3'(6 - k)) begin
        nErr++;
        $display("FAIL drain_order: got D=%h C=%0d, want D=%h C=%0d", oData, oCount, k, 6 - k);
      end
    end
    @(negedge clk);
    nVec++;
    if (oValid !== 1'b0 || oCount !== 3'd0) begin
      nErr++;
      $display("FAIL drain_empty: got V=%b C=%0d, want V=0 C=0", oValid, oCount);
    end
    iReady = 1'b0;
  endtask

  task automatic test_full_pushpop;
    logic prev;
    iReady = 1'b0;
    for (int i = 0; i < 4; i++) send(32'h10 + 32'(i), 16);
    prev = outA;
    toggleReq(32'h14);
    repeat (2) begin
      @(negedge clk);
      nVec++;
      if (oStall !== 1'b0) begin
        nErr++;
        $display("FAIL pushpop_prestall: got S=%b, want 0", oStall);
      end
    end
    iReady = 1'b1;
    @(negedge clk);
    expA = ~expA;
    nVec++;
    if (outA !== ~prev || oCount !== 3'd4 || oStall !== 1'b0 || oData !== 32'h11) begin
      nErr++;
      $display("FAIL pushpop_edge: got A=%b C=%0d S=%b D=%h, want A=%b C=4 S=0 D=11", outA, oCount, oStall, oData, ~prev);
    end
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      nVec++;
      if (oData !== 32'h10 + 32'(k) || oStall !== 1'b0) begin
        nErr++;
        $display("FAIL pushpop_order: got D=%h S=%b, want D=%h S=0", oData, oStall, 32'h10 + 32'(k));
      end
    end
    @(negedge clk);
    nVec++;
    if (oValid !== 1'b0) begin
      nErr++;
      $display("FAIL pushpop_empty: got V=%b, want 0", oValid);
    end
    iReady = 1'b0;
  endtask

  task automatic test_stream;
    int rx  = 0;
    int cyc = 0;
    fork
      begin
        for (int i = 0; i < 16; i++) send(32'h200 + 32'(i), 64);
      end
      begin
        while (rx < 16 && cyc < 3000) begin
          @(negedge clk);
          cyc++;
          nVec++;
          if (oCount > 3'd4) begin
            nErr++;
            $display("FAIL stream_count: got %0d, want <= 4", oCount);
          end
          iReady = 1'($urandom_range(0, 1));
          if (oValid && iReady) begin
            nVec++;
            if (oData !== 32'h200 + 32'(rx)) begin
              nErr++;
              $display("FAIL stream_order: got %h, want %h", oData, 32'h200 + 32'(rx));
            end
            rx++;
          end
        end
      end
    join
    nVec++;
    if (rx != 16) begin
      nErr++;
      $display("FAIL stream_timeout: got %0d words, want 16", rx);
    end
    @(negedge clk);
    iReady = 1'b0;
    nVec++;
    if (oValid !== 1'b0 || oCount !== 3'd0 || outA !== expA) begin
      nErr++;
      $display("FAIL stream_end: got V=%b C=%0d A=%b, want V=0 C=0 A=%b", oValid, oCount, outA, expA);
    end
  endtask

  task automatic test_reset_mid;
    int e;
    iReady = 1'b0;
    for (int i = 1; i <= 3; i++) send(32'h30 + 32'(i), 16);
    nVec++;
    if (oCount !== 3'd3) begin
      nErr++;
      $display("FAIL mid_fill: got C=%0d, want 3", oCount);
    end
    rst = 1'b0;
    #1;
    nVec++;
    if ({outA, oValid, oCount, oStall, oData} !== 38'd0) begin
      nErr++;
      $display("FAIL mid_async_reset: got %b/%b/%0d/%b/%h, want all zero", outA, oValid, oCount, oStall, oData);
    end
    inR    = 1'b1;
    inData = 32'hABCD0001;
    @(negedge clk);
    nVec++;
    if ({outA, oValid, oCount, oStall, oData} !== 38'd0) begin
      nErr++;
      $display("FAIL mid_reset_hold: got %b/%b/%0d/%b/%h, want all zero", outA, oValid, oCount, oStall, oData);
    end
    @(negedge clk);
    rst = 1'b1;
    waitAck(1'b0, 8, e);
    nVec++;
    if (outA !== 1'b1 || oCount !== 3'd1 || oValid !== 1'b1 || oData !== 32'hABCD0001) begin
      nErr++;
      $display("FAIL mid_recapture: got A=%b C=%0d V=%b D=%h, want A=1 C=1 V=1 D=abcd0001", outA, oCount, oValid, oData);
    end
    repeat (6) @(negedge clk);
    nVec++;
    if (outA !== 1'b1 || oCount !== 3'd1 || oStall !== 1'b0) begin
      nErr++;
      $display("FAIL mid_single: got A=%b C=%0d S=%b, want A=1 C=1 S=0", outA, oCount, oStall);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_single;
    test_fill_stall;
    test_full_pushpop;
    test_stream;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
